// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU and its two-requester front end:
//   function-code constants, the arbiter FSM state type and the
//   is_muldiv() helper that selects the multi-cycle execute latency.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int CTRL_W = 4;
  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t OP_ADD = 4'b1111;
  localparam ctrl_t OP_SUB = 4'b1110;
  localparam ctrl_t OP_AND = 4'b1101;
  localparam ctrl_t OP_OR  = 4'b1100;
  localparam ctrl_t OP_MUL = 4'b0001;
  localparam ctrl_t OP_DIV = 4'b0010;
  localparam ctrl_t OP_SLL = 4'b1010;
  localparam ctrl_t OP_SLR = 4'b1011;
  localparam ctrl_t OP_ROL = 4'b1001;
  localparam ctrl_t OP_ROR = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_muldiv(input ctrl_t ctrl);
    return (ctrl == OP_MUL) || (ctrl == OP_DIV);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational ALU.  R carries the low result (with carry/borrow in
//   bit W), S the high product word or the remainder.  MUL/DIV are unsigned;
//   ADD/SUB flag signed overflow; shifts/rotates use i_b modulo W.
//   Ports:
//     i_a, i_b  [W-1:0]  operands
//     i_ctrl    [CW-1:0] function code (alu_pkg OP_*)
//     o_r, o_s  [W:0]    low / high result
//     o_exc              overflow, divide by zero or unknown function code
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  input  logic [CW-1:0] i_ctrl,
  output logic [W:0]    o_r,
  output logic [W:0]    o_s,
  output logic          o_exc
);

  localparam int SH_W = $clog2(W);

  logic [SH_W-1:0] w_sh;
  logic [W:0]      w_sum;
  logic [W:0]      w_diff;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_rol;
  logic [W-1:0]    w_ror;
  logic            w_add_ovf;
  logic            w_sub_ovf;

  assign w_sh   = i_b[SH_W-1:0];
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod = (2*W)'(i_a) * (2*W)'(i_b);
  // Rotating the doubled word lets one shifter handle wrap-around.
  assign w_rol  = W'(({i_a, i_a} << w_sh) >> W);
  assign w_ror  = W'({i_a, i_a} >> w_sh);

  assign w_add_ovf = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1]  != i_a[W-1]);
  assign w_sub_ovf = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_r   = '0;
    o_s   = '0;
    o_exc = 1'b0;
    case (i_ctrl)
      OP_ADD: begin o_r = w_sum;  o_exc = w_add_ovf; end
      OP_SUB: begin o_r = w_diff; o_exc = w_sub_ovf; end
      OP_AND: o_r = {1'b0, i_a & i_b};
      OP_OR:  o_r = {1'b0, i_a | i_b};
      OP_MUL: begin
        o_r = {1'b0, w_prod[W-1:0]};
        o_s = {1'b0, w_prod[2*W-1:W]};
      end
      OP_DIV: begin
        if (i_b == '0) begin
          o_exc = 1'b1;
        end else begin
          o_r = {1'b0, i_a / i_b};
          o_s = {1'b0, i_a % i_b};
        end
      end
      OP_SLL: o_r = {1'b0, i_a << w_sh};
      OP_SLR: o_r = {1'b0, i_a >> w_sh};
      OP_ROL: o_r = {1'b0, w_rol};
      OP_ROR: o_r = {1'b0, w_ror};
      default: o_exc = 1'b1;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker.  When both requests are present the one that
//   did not win last time is chosen; a lone request always wins.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     i_req   [1:0]   request vector
//     i_update        a grant was taken this cycle; remember its winner
//     o_grant [1:0]   one-hot winner, zero when nothing requests
//     o_grant_id      index of the winner
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  // Reset to 1 so requester 0 wins the first contested grant.
  logic r_last_grant;

  always_comb begin
    o_grant_id = 1'b0;
    case (i_req)
      2'b11:   o_grant_id = ~r_last_grant;
      2'b10:   o_grant_id = 1'b1;
      default: o_grant_id = 1'b0;
    endcase
    o_grant = (|i_req) ? (o_grant_id ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= o_grant_id;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU between requester 0 (integer pipeline) and requester 1
//   (address/branch unit).  A winning request is registered, executed for
//   1 cycle (MUL/DIV: MULDIV_LATENCY cycles) and the result is held until the
//   consumer takes it.  One transaction is in flight at a time.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     req_valid[1:0] / req_ready[1:0] request handshake per requester
//     req{0,1}_A, req{0,1}_B, req{0,1}_Ctrl   operands and function code
//     rsp_valid / rsp_ready           result handshake
//     rsp_id, rsp_R, rsp_S, rsp_exc   owner, low/high result, exception
//   Optional (`define ALU_ARBITER_STATS_EN):
//     grant_cnt0, grant_cnt1, exc_cnt saturating 16-bit event counters
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int REGISTER_DATA_BIT_WIDTH = 16,
  parameter int ALU_CONTROL_WIDTH       = 4,
  parameter int MULDIV_LATENCY          = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         req_valid,
  output logic [1:0]                         req_ready,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] req0_A,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] req0_B,
  input  logic [ALU_CONTROL_WIDTH-1:0]       req0_Ctrl,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] req1_A,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] req1_B,
  input  logic [ALU_CONTROL_WIDTH-1:0]       req1_Ctrl,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic                               rsp_id,
  output logic [REGISTER_DATA_BIT_WIDTH-1:0] rsp_R,
  output logic [REGISTER_DATA_BIT_WIDTH-1:0] rsp_S,
  output logic                               rsp_exc
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [15:0]                        grant_cnt0,
  output logic [15:0]                        grant_cnt1,
  output logic [15:0]                        exc_cnt
`endif
);

  localparam int W     = REGISTER_DATA_BIT_WIDTH;
  localparam int CNT_W = $clog2(MULDIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MD  = CNT_W'(MULDIV_LATENCY);

  if (MULDIV_LATENCY < 1) begin : g_bad_latency
    $error("alu_arbiter: MULDIV_LATENCY must be at least 1");
  end

  state_t                       r_state, w_next_state;
  logic [W-1:0]                 r_a, r_b;
  logic [ALU_CONTROL_WIDTH-1:0] r_ctrl;
  logic                         r_id;
  logic                         r_div0;
  logic [CNT_W-1:0]             r_cnt;
  logic [W-1:0]                 r_rsp_r, r_rsp_s;
  logic                         r_rsp_exc;

  logic [1:0]                   w_grant;
  logic                         w_grant_id;
  logic                         w_accept;
  logic                         w_last_cycle;
  logic [W-1:0]                 w_sel_a, w_sel_b;
  logic [ALU_CONTROL_WIDTH-1:0] w_sel_ctrl;
  logic                         w_sel_div0;
  logic [W:0]                   w_alu_r, w_alu_s;
  logic                         w_alu_exc;
  logic [1:0]                   w_unused_alu_msb;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req_valid),
    .i_update   (w_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  alu #(
    .W  (W),
    .CW (ALU_CONTROL_WIDTH)
  ) u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_ctrl (r_ctrl),
    .o_r    (w_alu_r),
    .o_s    (w_alu_s),
    .o_exc  (w_alu_exc)
  );

  // Results are W bits wide; the ALU's carry/borrow bits are dropped.
  assign w_unused_alu_msb = {w_alu_r[W], w_alu_s[W]};

  assign w_accept     = |(req_valid & req_ready);
  assign w_last_cycle = (r_state == EXEC) && (r_cnt == CNT_ONE);
  assign w_sel_a      = w_grant_id ? req1_A    : req0_A;
  assign w_sel_b      = w_grant_id ? req1_B    : req0_B;
  assign w_sel_ctrl   = w_grant_id ? req1_Ctrl : req0_Ctrl;
  // Divide by zero is resolved at accept: single-cycle, result forced.
  assign w_sel_div0   = (w_sel_ctrl == OP_DIV) && (w_sel_b == '0);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)     w_next_state = EXEC;
      EXEC:    if (w_last_cycle) w_next_state = RESP;
      RESP:    if (rsp_ready)    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM: outputs.  Requests are offered only while idle, so a response
  // handshake never overlaps a new accept.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready = w_grant;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand and result registers are reset too, so an aborted
    // transaction leaves no stale data visible on rsp_* after reset.
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_ctrl    <= '0;
      r_id      <= 1'b0;
      r_div0    <= 1'b0;
      r_cnt     <= '0;
      r_rsp_r   <= '0;
      r_rsp_s   <= '0;
      r_rsp_exc <= 1'b0;
    end else if (w_accept) begin
      r_a    <= w_sel_a;
      r_b    <= w_sel_b;
      r_ctrl <= w_sel_ctrl;
      r_id   <= w_grant_id;
      r_div0 <= w_sel_div0;
      r_cnt  <= (is_muldiv(w_sel_ctrl) && !w_sel_div0) ? CNT_MD : CNT_ONE;
    end else if (r_state == EXEC) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last_cycle) begin
        r_rsp_r   <= r_div0 ? '0   : w_alu_r[W-1:0];
        r_rsp_s   <= r_div0 ? '0   : w_alu_s[W-1:0];
        r_rsp_exc <= r_div0 ? 1'b1 : w_alu_exc;
      end
    end
  end

  assign rsp_id  = r_id;
  assign rsp_R   = r_rsp_r;
  assign rsp_S   = r_rsp_s;
  assign rsp_exc = r_rsp_exc;

`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] r_grant_cnt0, r_grant_cnt1, r_exc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_exc_cnt    <= '0;
    end else begin
      if (w_accept && !w_grant_id && (r_grant_cnt0 != 16'hFFFF))
        r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_accept && w_grant_id && (r_grant_cnt1 != 16'hFFFF))
        r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      if (rsp_valid && rsp_ready && r_rsp_exc && (r_exc_cnt != 16'hFFFF))
        r_exc_cnt <= r_exc_cnt + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign exc_cnt    = r_exc_cnt;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters (0: integer pipeline, 1: address/branch unit) using round-robin arbitration with valid/ready handshakes.
- Registers the ALU operands, sequences multi-cycle MUL/DIV, and holds the result until the consumer accepts it.
- Sits between the issue stage and the ALU instance; it owns that ALU instance.

Parameters:
- REGISTER_DATA_BIT_WIDTH, 16, operand/result width (W).
- ALU_CONTROL_WIDTH, 4, function-code width.
- MULDIV_LATENCY, 4, execute cycles for MUL/DIV (>=1); all other ops take 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept (one-hot or zero).
- req0_A, req0_B, req1_A, req1_B  in  W each  operands.
- req0_Ctrl, req1_Ctrl  in  ALU_CONTROL_WIDTH each  function codes.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_R  out  W  low result/quotient.
- rsp_S  out  W  high product/remainder.
- rsp_exc  out  1  exception (overflow, invalid code, divide by zero).

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_R=0, rsp_S=0, rsp_exc=0, state=IDLE, last_grant=1 (requester 0 wins first), counter=0, operand registers=0.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready is combinational. It asserts for the winning valid requester and otherwise stays 0.
  - Winner when both are valid: the requester that is not last_grant.
  - Winner when one is valid: that requester.
- Accept edge (req_valid[i] & req_ready[i]): register A, B, Ctrl and id; set last_grant=i; load the counter with 1, or MULDIV_LATENCY for MUL/DIV; go to EXEC.
- EXEC: req_ready=0. Counter decrements each cycle. When the counter reaches 1, capture the ALU outputs into rsp_R, rsp_S and rsp_exc, then go to RESP.
  - Simple op: rsp_valid rises on the 2nd edge after acceptance.
  - MUL/DIV: rsp_valid rises on the (MULDIV_LATENCY+1)th edge after acceptance.
- Divide by zero: DIV with B==0 is detected at accept. It uses latency 1, forces rsp_R=0, rsp_S=0, rsp_exc=1, and is not computed by the ALU.
- Invalid function code: the ALU exception passes through to rsp_exc. Latency is 1.
- RESP: rsp_valid=1. rsp_* stays stable until rsp_ready. On handshake: rsp_valid=0, go to IDLE. No new request is accepted in the same cycle. Maximum throughput is one op per 3 cycles for simple ops.
- Request side: requesters hold A/B/Ctrl stable while valid and not yet accepted. A dropped req_valid before acceptance is legal and not recorded.
- Width rules: R is the low W bits and S the high W bits of the 2W ALU result. The ALU's W+1-bit R/S outputs are truncated to W.
- Reset mid-operation: aborts any EXEC/RESP transaction immediately. No response is produced and all outputs return to reset values.
- Counter never wraps: MULDIV_LATENCY<1 is an elaboration error.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 and exc_cnt, each 16 bits, reset to 0.
  - grant_cnt0/grant_cnt1 increment on accept edges. exc_cnt increments on response handshakes with rsp_exc=1.
  - All three saturate at 16'hFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - function-code constants (ADD=1111, SUB=1110, AND=1101, OR=1100, MUL=0001, DIV=0010, SLL=1010, SLR=1011, ROL=1001, ROR=1000);
  - the state enum (IDLE/EXEC/RESP);
  - the is_muldiv helper.
- One sub-module: rr_arb2, the 2-way round-robin picker holding last_grant.
- The ALU itself is instantiated unchanged.

Test Plan:
- Simple op: reset, then req0 ADD A=0x0003 B=0x0004 -> req_ready[0] same cycle; rsp_valid 2 edges later; rsp_R=0x0007, rsp_S=0, rsp_exc=0, rsp_id=0.
- Round robin: both requesters valid continuously with ADDs, rsp_ready tied 1 -> grants alternate 0,1,0,1; no requester is starved.
- Multi-cycle: req1 MUL 0x0100*0x0100, MULDIV_LATENCY=4 -> rsp_valid on the 5th edge; rsp_R=0x0000, rsp_S=0x0001, rsp_id=1.
- Divide by zero: DIV A=0x0010 B=0 -> latency 1; rsp_exc=1, R=S=0. Overflow: ADD 0x7FFF+0x0001 -> rsp_exc=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout; a pending request is accepted 1 cycle after the handshake.
- Reset: rst_n asserted mid-EXEC of a MUL -> outputs cleared asynchronously; after release, req0 wins first grant. With ALU_ARBITER_STATS_EN: counters read 0.
